// File: rtl/fanout_tree_add.sv
// Broadcast adder: one registered operand fans out through a register tree to
// NUM_ADDERS lanes, each adding/subtracting its own constant offset.
// Latency L+2 enabled cycles; en=0 freezes every stage, no handshake.
module fanout_tree_add #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_ADDERS  = 20,
  parameter int MAX_FANOUT  = 4,
  parameter int OFFSET_BASE = 0,
  parameter int OFFSET_STEP = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_sub,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out [NUM_ADDERS],
  output logic [COUNT_WIDTH-1:0] result_count
);

  // ---------------------------------------------------------------------------
  // Elaboration-time tree geometry
  // ---------------------------------------------------------------------------
  function automatic int pow_i(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Smallest L with MAX_FANOUT^L >= NUM_ADDERS.
  function automatic int calc_depth(input int n, input int f);
    int l;
    int p;
    l = 0;
    p = 1;
    while (p < n) begin
      p = p * f;
      l = l + 1;
    end
    return l;
  endfunction

  localparam int L = calc_depth(NUM_ADDERS, MAX_FANOUT);

  // Number of copies held at duplication level k.
  function automatic int copies(input int k);
    return ceil_div(NUM_ADDERS, pow_i(MAX_FANOUT, k));
  endfunction

  // Copies are stored flat, level L first; this is where level k begins.
  function automatic int lvl_base(input int k);
    int s;
    s = 0;
    for (int m = k + 1; m <= L; m++) s = s + copies(m);
    return s;
  endfunction

  localparam int TOTAL = lvl_base(0);

  // Flat index of the register feeding copy g; -1 means stage 0.
  function automatic int src_of(input int g);
    int r;
    r = -1;
    for (int k = L; k >= 1; k--) begin
      if (g >= lvl_base(k) && g < lvl_base(k) + copies(k)) begin
        if (k == L) r = -1;
        else r = lvl_base(k + 1) + (g - lvl_base(k)) / MAX_FANOUT;
      end
    end
    return r;
  endfunction

  // Lane offset, wrapped to the lane width (DATA_WIDTH up to 64).
  function automatic logic [DATA_WIDTH-1:0] lane_off(input int i);
    logic [63:0] v;
    v = 64'(longint'(OFFSET_BASE) + longint'(i) * longint'(OFFSET_STEP));
    return v[DATA_WIDTH-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 0: input capture
  // ---------------------------------------------------------------------------
  logic                  s0_vld;
  logic [DATA_WIDTH-1:0] s0_dat;
  logic                  s0_sub;

  // Stage 0 valid; a valid coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (rst)     s0_vld <= 1'b0;
    else if (en) s0_vld <= in_valid;
  end

  // Stage 0 payload; qualified by s0_vld so it needs no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      s0_dat <= in_data;
      s0_sub <= in_sub;
    end
  end

  // Per-lane sources and the tap that drives out_valid.
  logic [DATA_WIDTH-1:0] lane_dat [NUM_ADDERS];
  logic                  lane_sub [NUM_ADDERS];
  logic                  lane_vld [NUM_ADDERS];
  logic                  out_vld_tap;

  // ---------------------------------------------------------------------------
  // Duplication tree
  // ---------------------------------------------------------------------------
  if (L > 0) begin : g_tree
    (* dont_merge *) logic [DATA_WIDTH-1:0] dup_dat [TOTAL];
    (* dont_merge *) logic                  dup_sub [TOTAL];
    (* dont_merge *) logic                  dup_vld [TOTAL];
    logic [DATA_WIDTH-1:0] nxt_dat [TOTAL];
    logic                  nxt_sub [TOTAL];
    logic                  nxt_vld [TOTAL];
    // Valid-only spine, one bit per level, so out_valid does not load a lane copy.
    logic [L:1]            spine_vld;

    for (genvar g = 0; g < TOTAL; g++) begin : g_copy
      localparam int SRC = src_of(g);
      if (SRC < 0) begin : g_root
        assign nxt_dat[g] = s0_dat;
        assign nxt_sub[g] = s0_sub;
        assign nxt_vld[g] = s0_vld;
      end else begin : g_node
        assign nxt_dat[g] = dup_dat[SRC];
        assign nxt_sub[g] = dup_sub[SRC];
        assign nxt_vld[g] = dup_vld[SRC];
      end
    end

    // Copy valids and spine advance together with the data; rst flushes them.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int g = 0; g < TOTAL; g++) dup_vld[g] <= 1'b0;
        spine_vld <= '0;
      end else if (en) begin
        for (int g = 0; g < TOTAL; g++) dup_vld[g] <= nxt_vld[g];
        spine_vld[L] <= s0_vld;
        for (int k = 1; k < L; k++) spine_vld[k] <= spine_vld[k+1];
      end
    end

    // Copy payloads; no reset, they are qualified by the copy valids.
    always_ff @(posedge clk) begin
      if (en) begin
        for (int g = 0; g < TOTAL; g++) begin
          dup_dat[g] <= nxt_dat[g];
          dup_sub[g] <= nxt_sub[g];
        end
      end
    end

    for (genvar i = 0; i < NUM_ADDERS; i++) begin : g_lane_src
      localparam int LSRC = lvl_base(1) + i / MAX_FANOUT;
      assign lane_dat[i] = dup_dat[LSRC];
      assign lane_sub[i] = dup_sub[LSRC];
      assign lane_vld[i] = dup_vld[LSRC];
    end

    assign out_vld_tap = spine_vld[1];
  end else begin : g_flat
    // Single lane: stage 0 feeds the lane and out_valid directly.
    for (genvar i = 0; i < NUM_ADDERS; i++) begin : g_lane_src
      assign lane_dat[i] = s0_dat;
      assign lane_sub[i] = s0_sub;
      assign lane_vld[i] = s0_vld;
    end
    assign out_vld_tap = s0_vld;
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  // Lane results load only when their source carries a valid item.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ADDERS; i++) begin
      if (rst) begin
        out[i] <= '0;
      end else if (en && lane_vld[i]) begin
        out[i] <= lane_sub[i] ? lane_dat[i] - lane_off(i)
                              : lane_dat[i] + lane_off(i);
      end
    end
  end

  // out_valid is a one-enabled-cycle pulse per item; it holds while en=0.
  always_ff @(posedge clk) begin
    if (rst)     out_valid <= 1'b0;
    else if (en) out_valid <= out_vld_tap;
  end

  // Count each pulse as it is launched so the count tracks out_valid; saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_count <= '0;
    end else if (en && out_vld_tap && (result_count != '1)) begin
      result_count <= result_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fanout_tree_add.sv
// Bench for fanout_tree_add: three configurations (default, L=0, L=1 with a
// 2-bit counter) share one stimulus stream and are checked every cycle
// against a delay-queue reference model.
module tb_fanout_tree_add;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sub;

  logic        ov0, ov1, ov2;
  logic [7:0]  o0 [20];
  logic [7:0]  o1 [1];
  logic [7:0]  o2 [4];
  logic [15:0] c0, c1;
  logic [1:0]  c2;

  fanout_tree_add u_dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_sub(in_sub), .out_valid(ov0), .out(o0), .result_count(c0)
  );

  fanout_tree_add #(.NUM_ADDERS(1)) u_l0 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_sub(in_sub), .out_valid(ov1), .out(o1), .result_count(c1)
  );

  fanout_tree_add #(.NUM_ADDERS(4), .MAX_FANOUT(8), .COUNT_WIDTH(2)) u_l1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_sub(in_sub), .out_valid(ov2), .out(o2), .result_count(c2)
  );

  // Reference model: each item reappears LAT-1 enabled edges after capture.
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       s;
  } item_t;

  item_t      pipe [3][$];
  int         n_of [3] = '{20, 1, 4};
  int         f_of [3] = '{4, 4, 8};
  int         cmax [3] = '{65535, 65535, 3};
  int         lat  [3];
  logic [7:0] m_out [3][20];
  logic       m_vld [3];
  int         m_cnt [3];

  int vectors = 0;
  int miscompares = 0;

  function automatic int depth(input int n, input int f);
    int l;
    int p;
    l = 0;
    p = 1;
    while (p < n) begin
      p = p * f;
      l++;
    end
    return l;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    item_t idle;
    idle = '{v: 1'b0, d: 8'h00, s: 1'b0};
    for (int d = 0; d < 3; d++) begin
      pipe[d].delete();
      for (int k = 0; k < lat[d] - 1; k++) pipe[d].push_back(idle);
      m_vld[d] = 1'b0;
      m_cnt[d] = 0;
      for (int i = 0; i < 20; i++) m_out[d][i] = 8'h00;
    end
  endtask

  task automatic model_clock();
    item_t it;
    item_t nw;
    if (rst) begin
      model_reset();
    end else if (en) begin
      nw = '{v: in_valid, d: in_data, s: in_sub};
      for (int d = 0; d < 3; d++) begin
        it = pipe[d].pop_front();
        pipe[d].push_back(nw);
        m_vld[d] = it.v;
        if (it.v) begin
          for (int i = 0; i < n_of[d]; i++)
            m_out[d][i] = it.s ? it.d - 8'(i) : it.d + 8'(i);
          if (m_cnt[d] < cmax[d]) m_cnt[d]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("ov0", ov0, m_vld[0]);
    check("cnt0", c0, m_cnt[0]);
    for (int i = 0; i < 20; i++) check($sformatf("out0[%0d]", i), o0[i], m_out[0][i]);
    check("ov1", ov1, m_vld[1]);
    check("cnt1", c1, m_cnt[1]);
    check("out1[0]", o1[0], m_out[1][0]);
    check("ov2", ov2, m_vld[2]);
    check("cnt2", c2, m_cnt[2]);
    for (int i = 0; i < 4; i++) check($sformatf("out2[%0d]", i), o2[i], m_out[2][i]);
  endtask

  // One clock: DUT and model both sample at the rising edge, compare at the falling one.
  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic s,
                       input logic e, input logic r);
    in_valid = v;
    in_data  = d;
    in_sub   = s;
    en       = e;
    rst      = r;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) lat[d] = depth(n_of[d], f_of[d]) + 2;
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    model_reset();
    @(negedge clk);
    step();
    step();
    check("rst_ov0", ov0, 1'b0);
    check("rst_cnt0", c0, 32'd0);

    // Single add of 0x10, explicit latency per configuration.
    drive(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      step();
      check($sformatf("lat0_c%0d", c), ov0, (c == lat[0] - 1));
      check($sformatf("lat1_c%0d", c), ov1, (c == lat[1] - 1));
      check($sformatf("lat2_c%0d", c), ov2, (c == lat[2] - 1));
      if (c == lat[0] - 1) begin
        check("add_out19", o0[19], 8'h23);
        check("add_cnt", c0, 32'd1);
      end
    end

    // Subtract with wrap-around.
    drive(1'b1, 8'h02, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) step();
    check("sub_out0", o0[0], 8'h02);
    check("sub_out3", o0[3], 8'hFF);
    check("sub_out19", o0[19], 8'hEF);

    // Back-to-back inputs with a two-cycle freeze in the middle.
    drive(1'b1, 8'h31, 1'b0, 1'b1, 1'b0); step();
    drive(1'b1, 8'h52, 1'b1, 1'b1, 1'b0); step();
    drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0); step(); step();
    drive(1'b1, 8'h73, 1'b0, 1'b1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 7; c++) step();

    // Reset two cycles after an input flushes it.
    drive(1'b1, 8'h44, 1'b0, 1'b1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); step();
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 7; c++) step();
    check("flush_cnt0", c0, 32'd0);
    check("flush_out5", o0[5], 8'h00);
    check("flush_ov0", ov0, 1'b0);

    // Five inputs: the 2-bit counter saturates at 3.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'(k * 17), 1'b0, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) step();
    check("sat_cnt2", c2, 32'd3);
    check("sat_cnt0", c0, 32'd5);

    // Randomized traffic with freezes and occasional resets.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
